serial_frame_dp: RTL
====================

SERIAL_FRAME_DP -- requirements
Module: serial_frame_dp

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: cmd_data  input  8  command byte to send in the next frame.
REQ-004 SHALL have port: cmd_valid  input  1  cmd_data valid.
REQ-005 SHALL have port: cmd_ready  output  1  holding register empty; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-006 SHALL have port: trst  input  1  frame control from the interface FSM; 0 = idle or load, 1 = frame active.
REQ-007 SHALL have port: dq_en  input  1  write phase and tristate enable from the interface FSM.
REQ-008 SHALL have port: sr_en  input  1  one-cycle bit strobe from the interface FSM.
REQ-009 SHALL have port: dq_in  input  1  serial data from the device.
REQ-010 SHALL have port: dq_out  output  1  serial data to the device; meaningful only while dq_en=1.
REQ-011 SHALL have port: rd_data  output  8  received byte.
REQ-012 SHALL have port: rd_valid  output  1  rd_data valid.
REQ-013 SHALL have port: rd_ready  input  1  consumer accepts rd_data.
REQ-014 SHALL have port: frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-015 SHALL have port: overrun  output  1  sticky; a received byte was dropped.
REQ-016 SHALL have port: parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without the macro.

Function
REQ-017 SHALL detect frame start when trst is 1 in the current cycle and was 0 in the previous cycle, and frame end when trst is 0 in the current cycle and was 1 in the previous cycle, using a registered copy of trst.
REQ-018 SHALL, at frame start, load tx_sr from the holding register and clear hold_full if hold_full=1, otherwise load 0x00 and pulse frame_err for one cycle.
REQ-019 SHALL drive cmd_ready = !hold_full; a command accepted in the same cycle as frame start SHALL be held for the next frame and SHALL NOT be used by the current frame.
REQ-020 SHALL drive dq_out = tx_sr[7] (MSB first) when dq_en=1, else 0; on sr_en=1 with dq_en=1, tx_sr SHALL shift left with a 0 fill.
REQ-021 SHALL, on sr_en=1 with dq_en=0 during a frame, increment rd_cnt (4 bits, saturating at 15); strobe 1 is the turnaround/parity bit, strobes 2-9 shift dq_in into rx_sr MSB first, and strobes above 9 are ignored.
REQ-022 SHALL ignore sr_en while trst=0.
REQ-023 SHALL, at frame end with rd_cnt=9, deliver rx_sr: if rd_valid=0, or rd_valid=1 with rd_ready=1 in the same cycle, load rd_data and set rd_valid=1; otherwise drop the byte and set overrun.
REQ-024 SHALL, at frame end with rd_cnt≠9, pulse frame_err, deliver no byte, and leave rd_valid and rd_data unchanged.
REQ-025 SHALL clear rd_valid on rd_valid and rd_ready when no delivery occurs in that cycle.
REQ-026 SHALL clear rd_cnt at frame start.
REQ-027 SHALL deliver rd_data with a latency of exactly 1 cycle after frame end is detected.

Reset
REQ-028 SHALL, while rst=1, set: cmd_ready=0, dq_out=0, rd_data=0x00, rd_valid=0, frame_err=0, overrun=0, parity_err=0; clear hold_full, tx_sr, rx_sr and rd_cnt; set registered trst to 0.
REQ-029 SHALL drive cmd_ready=1 from the first cycle after rst deasserts.
REQ-030 SHALL, when rst asserts mid-frame, abandon the frame with no delivery and no error pulse; the next frame start requires trst to go low and then high again.
REQ-031 SHALL clear overrun only by rst.

Configuration
REQ-032 SHALL, with SERIAL_FRAME_DP_PARITY_EN defined, latch read strobe 1 as a parity bit; at frame end with rd_cnt=9, if parity bit XOR (XOR of rx_sr) is 1, SHALL pulse parity_err and drop the byte without setting overrun.
REQ-033 SHALL, without SERIAL_FRAME_DP_PARITY_EN, discard read strobe 1, tie parity_err to 0, and include no parity logic.

Verification
REQ-034 Bench SHALL cover: cmd 0xA5 accepted, one frame (8 write strobes) -> dq_out sequence at write strobes 1,0,1,0,0,1,0,1; cmd_ready=1 after frame start.
REQ-035 Bench SHALL cover: read strobes carrying 0, then 0x3C MSB first, rd_ready=1 -> rd_valid=1 one cycle after frame end, rd_data=0x3C; rd_valid=0 the cycle after.
REQ-036 Bench SHALL cover: two frames with rd_ready=0 -> first byte retained, second dropped, overrun=1 until rst.
REQ-037 Bench SHALL cover: frame start with no command -> frame_err pulse, dq_out=0 for all write strobes.
REQ-038 Bench SHALL cover: frame ending after 7 read strobes -> frame_err pulse, rd_valid unchanged; rst asserted mid-frame -> all outputs at reset values, no delivery.
REQ-039 Bench SHALL cover, with SERIAL_FRAME_DP_PARITY_EN defined: parity bit 1 with data 0x3C -> parity_err pulse, no delivery; parity bit 0 -> 0x3C delivered.

Source files
------------

// File: rtl/serial_frame_dp_if.sv
// Bundles the command, device-serial and read-back signals of serial_frame_dp.
// master = the side driving the frame controls and commands, slave = the datapath.
interface serial_frame_dp_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       trst;
  logic       dq_en;
  logic       sr_en;
  logic       dq_in;
  logic       dq_out;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output cmd_data, cmd_valid, trst, dq_en, sr_en, dq_in, rd_ready,
    input  cmd_ready, dq_out, rd_data, rd_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  cmd_data, cmd_valid, trst, dq_en, sr_en, dq_in, rd_ready,
    output cmd_ready, dq_out, rd_data, rd_valid, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/serial_frame_dp.sv
// Serial frame datapath: one command byte out MSB first, one byte back per frame.
// Define SERIAL_FRAME_DP_PARITY_EN to check the turnaround bit as even parity.
module serial_frame_dp (
  input logic              clk,
  input logic              rst,
  serial_frame_dp_if.slave bus
);

  logic       r_trst_q;
  logic       r_armed;
  logic       r_active;
  logic       r_hold_full;
  logic [7:0] r_hold;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [3:0] r_rd_cnt;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic       r_frame_err;
  logic       r_overrun;

  logic w_start;
  logic w_end;
  logic w_accept;
  logic w_strobe;
  logic w_wr_strobe;
  logic w_rd_strobe;
  logic w_cnt_ok;
  logic w_par_bad;
  logic w_deliver;

  // r_armed blocks a false start when reset drops while trst is still high
  assign w_start     = bus.trst & ~r_trst_q & r_armed;
  assign w_end       = ~bus.trst & r_trst_q & r_active;
  assign w_accept    = bus.cmd_valid & bus.cmd_ready;
  assign w_strobe    = bus.sr_en & bus.trst & r_active;
  assign w_wr_strobe = w_strobe & bus.dq_en;
  assign w_rd_strobe = w_strobe & ~bus.dq_en;
  assign w_cnt_ok    = (r_rd_cnt == 4'd9);
  assign w_deliver   = w_end & w_cnt_ok & ~w_par_bad & (~r_rd_valid | bus.rd_ready);

`ifdef SERIAL_FRAME_DP_PARITY_EN
  logic r_par;
  logic r_parity_err;

  assign w_par_bad      = r_par ^ (^r_rx_sr);
  assign bus.parity_err = r_parity_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_end & w_cnt_ok & w_par_bad;
      if (w_rd_strobe && r_rd_cnt == 4'd0) r_par <= bus.dq_in;
    end
  end
`else
  assign w_par_bad      = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trst_q    <= 1'b0;
      r_armed     <= 1'b0;
      r_active    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold      <= 8'h00;
      r_tx_sr     <= 8'h00;
      r_rx_sr     <= 8'h00;
      r_rd_cnt    <= 4'd0;
      r_rd_data   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_trst_q    <= bus.trst;
      r_armed     <= r_armed | ~bus.trst;
      r_frame_err <= (w_start & ~r_hold_full) | (w_end & ~w_cnt_ok);

      if (w_start) r_active <= 1'b1;
      else if (w_end) r_active <= 1'b0;

      // A command accepted on the start cycle lands in the holding register only
      if (w_accept) begin
        r_hold      <= bus.cmd_data;
        r_hold_full <= 1'b1;
      end else if (w_start && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      if (w_start) r_tx_sr <= r_hold_full ? r_hold : 8'h00;
      else if (w_wr_strobe) r_tx_sr <= {r_tx_sr[6:0], 1'b0};

      if (w_start) begin
        r_rd_cnt <= 4'd0;
      end else if (w_rd_strobe) begin
        if (r_rd_cnt != 4'd15) r_rd_cnt <= r_rd_cnt + 4'd1;
        if (r_rd_cnt >= 4'd1 && r_rd_cnt <= 4'd8) r_rx_sr <= {r_rx_sr[6:0], bus.dq_in};
      end

      if (w_deliver) begin
        r_rd_data  <= r_rx_sr;
        r_rd_valid <= 1'b1;
      end else if (r_rd_valid && bus.rd_ready) begin
        r_rd_valid <= 1'b0;
      end

      if (w_end && w_cnt_ok && !w_par_bad && r_rd_valid && !bus.rd_ready) r_overrun <= 1'b1;
    end
  end

  assign bus.cmd_ready = ~r_hold_full & ~rst;
  assign bus.dq_out    = bus.dq_en & r_tx_sr[7] & ~rst;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
